// File: rtl/mem_access_unit.sv
// MEM-stage load/store initiator: drives a word-only data memory, sub-word stores as read-modify-write.
// Optional alignment checking is enabled by defining MEM_ALIGN_CHECK_EN.
module mem_access_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic        done,
    output logic [31:0] rdata,
    output logic        misalign,
    output logic [9:0]  dm_addr,
    output logic [31:0] dm_din,
    output logic        dm_we,
    input  logic [31:0] dm_dout
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_WR   = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [11:0] areg_q, areg_d;
    logic [31:0] wreg_q, wreg_d;
    logic [1:0]  size_q, size_d;
    logic        we_q, we_d;
    logic        sext_q, sext_d;
    logic [31:0] mbuf_q, mbuf_d;
    logic [31:0] rdata_q, rdata_d;

    logic        bad_align;
    logic [1:0]  size_eff;
    logic        unused_addr_hi;

    // Upper address bits alias onto the 4 KiB window.
    assign unused_addr_hi = ^addr[31:12];

`ifdef MEM_ALIGN_CHECK_EN
    logic mis_q, mis_d;
    assign bad_align = (size == 2'b11)
                    || (size == 2'b01 && addr[0])
                    || (size == 2'b10 && addr[1:0] != 2'b00);
    assign size_eff  = size;
`else
    assign bad_align = 1'b0;
    assign size_eff  = (size == 2'b11) ? 2'b10 : size;
`endif

    // Load lane extraction; half selection uses only addr[1], word ignores addr[1:0].
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] load_val;

    assign ld_byte = dm_dout[{areg_q[1:0], 3'b000} +: 8];
    assign ld_half = dm_dout[{areg_q[1], 4'b0000} +: 16];

    always_comb begin
        load_val = dm_dout;
        case (size_q)
            2'b00:   load_val = sext_q ? {{24{ld_byte[7]}}, ld_byte} : {24'h0, ld_byte};
            2'b01:   load_val = sext_q ? {{16{ld_half[15]}}, ld_half} : {16'h0, ld_half};
            default: load_val = dm_dout;
        endcase
    end

    // Read-modify-write merge: replace only the addressed byte lanes of the buffered word.
    logic [3:0]  lane_hit;
    logic [31:0] merged;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign lane_hit[gi] = (size_q == 2'b00) ? (areg_q[1:0] == 2'(gi))
                                                    : (areg_q[1] == 1'(gi / 2));
            assign merged[8*gi +: 8] = lane_hit[gi]
                ? ((size_q == 2'b00) ? wreg_q[7:0] : wreg_q[8*(gi%2) +: 8])
                : mbuf_q[8*gi +: 8];
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        areg_d  = areg_q;
        wreg_d  = wreg_q;
        size_d  = size_q;
        we_d    = we_q;
        sext_d  = sext_q;
        mbuf_d  = mbuf_q;
        rdata_d = rdata_q;
`ifdef MEM_ALIGN_CHECK_EN
        mis_d   = mis_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    areg_d = addr[11:0];
                    wreg_d = wdata;
                    size_d = size_eff;
                    we_d   = we;
                    sext_d = sign_ext;
`ifdef MEM_ALIGN_CHECK_EN
                    mis_d  = bad_align;
`endif
                    if (bad_align) begin
                        rdata_d = 32'h0;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_ACC;
                    end
                end
            end
            S_ACC: begin
                if (!we_q) begin
                    rdata_d = load_val;
                    state_d = S_DONE;
                end else if (size_q == 2'b10) begin
                    state_d = S_DONE;
                end else begin
                    mbuf_d  = dm_dout;
                    state_d = S_WR;
                end
            end
            S_WR:    state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            areg_q  <= 12'h0;
            wreg_q  <= 32'h0;
            size_q  <= 2'b00;
            we_q    <= 1'b0;
            sext_q  <= 1'b0;
            mbuf_q  <= 32'h0;
            rdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            areg_q  <= areg_d;
            wreg_q  <= wreg_d;
            size_q  <= size_d;
            we_q    <= we_d;
            sext_q  <= sext_d;
            mbuf_q  <= mbuf_d;
            rdata_q <= rdata_d;
        end
    end

`ifdef MEM_ALIGN_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst) mis_q <= 1'b0;
        else     mis_q <= mis_d;
    end
    assign misalign = done && mis_q;
`else
    assign misalign = 1'b0;
`endif

    // Reset gating aborts an in-flight write and drops a pending completion.
    assign stall   = !rst && ((state_q == S_IDLE && req) || state_q == S_ACC || state_q == S_WR);
    assign done    = !rst && (state_q == S_DONE);
    assign dm_we   = !rst && ((state_q == S_ACC && we_q && size_q == 2'b10) || state_q == S_WR);
    assign dm_din  = !dm_we ? 32'h0 : ((state_q == S_WR) ? merged : wreg_q);
    assign dm_addr = areg_q[11:2];
    assign rdata   = rdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed testbench for mem_access_unit with a word-wide behavioural data memory.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst, req, we, sign_ext;
    logic [1:0]  size;
    logic [31:0] addr, wdata;
    logic        stall, done, misalign, dm_we;
    logic [31:0] rdata, dm_din, dm_dout;
    logic [9:0]  dm_addr;

    logic [31:0] mem [0:1023];
    logic        bd_we;
    logic [9:0]  bd_addr;
    logic [31:0] bd_data;

    int checks = 0;
    int errors = 0;
    int cycle_cnt = 0;
    int done_count = 0;

    always #5 clk = ~clk;

    mem_access_unit dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .size(size), .sign_ext(sign_ext),
        .addr(addr), .wdata(wdata), .stall(stall), .done(done), .rdata(rdata),
        .misalign(misalign), .dm_addr(dm_addr), .dm_din(dm_din), .dm_we(dm_we),
        .dm_dout(dm_dout)
    );

    assign dm_dout = mem[dm_addr];

    always @(posedge clk) begin
        cycle_cnt <= cycle_cnt + 1;
        if (dm_we === 1'b1)  mem[dm_addr] <= dm_din;
        else if (bd_we)      mem[bd_addr] <= bd_data;
    end

    always @(negedge clk) if (done === 1'b1) done_count <= done_count + 1;

    task automatic poke(input logic [9:0] a, input logic [31:0] d);
        bd_we = 1'b1; bd_addr = a; bd_data = d;
        @(posedge clk); #1;
        bd_we = 1'b0;
    endtask

    // Issues one request (req held through DONE) and records per-cycle behaviour.
    task automatic run_access(input logic w, input logic [1:0] sz, input logic sx,
                              input logic [31:0] a, input logic [31:0] wd,
                              output int dcyc, output int dabs, output logic [7:0] stl,
                              output logic [7:0] wem, output logic [31:0] din,
                              output logic mis, output logic [31:0] rd);
        logic fin;
        req = 1'b1; we = w; size = sz; sign_ext = sx; addr = a; wdata = wd;
        dcyc = -1; dabs = -1; stl = 8'h0; wem = 8'h0; din = 32'h0; mis = 1'b0; rd = 32'h0;
        fin = 1'b0;
        for (int c = 0; c < 8 && !fin; c++) begin
            #1;
            stl[c] = stall;
            wem[c] = dm_we;
            if (dm_we === 1'b1) din = dm_din;
            if (done === 1'b1) begin
                dcyc = c; dabs = cycle_cnt; mis = misalign; rd = rdata; fin = 1'b1;
            end
            @(posedge clk); #1;
        end
        req = 1'b0;
        $display("access we=%0b size=%0d sext=%0b addr=%h wdata=%h -> done_cycle=%0d rdata=%h misalign=%0b dm_we_mask=%b",
                 w, sz, sx, a, wd, dcyc, rd, mis, wem);
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 1'b1; we = 1'b0; size = 2'b10; sign_ext = 1'b0;
        addr = 32'h40; wdata = 32'h0; bd_we = 1'b0; bd_addr = 10'h0; bd_data = 32'h0;
        poke(10'h010, 32'h87654321);
        poke(10'h011, 32'h00000000);
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", stall); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL reset_misalign: got %b expected 0", misalign); end
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", rdata); end
        checks++; if (dm_we !== 1'b0) begin errors++; $display("FAIL reset_dm_we: got %b expected 0", dm_we); end
        checks++; if (dm_din !== 32'h0) begin errors++; $display("FAIL reset_dm_din: got %h expected 0", dm_din); end
        checks++; if (dm_addr !== 10'h0) begin errors++; $display("FAIL reset_dm_addr: got %h expected 0", dm_addr); end
        req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_load();
        int dc, da; logic [7:0] st, wm; logic [31:0] dn, rd; logic ms;
        run_access(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, dc, da, st, wm, dn, ms, rd);
        checks++; if (dc !== 2) begin errors++; $display("FAIL lw_done_cycle: got %0d expected 2", dc); end
        checks++; if (st[2:0] !== 3'b011) begin errors++; $display("FAIL lw_stall: got %b expected 011", st[2:0]); end
        checks++; if (wm !== 8'h0) begin errors++; $display("FAIL lw_dm_we: got %b expected 0", wm); end
        checks++; if (rd !== 32'h87654321) begin errors++; $display("FAIL lw_rdata: got %h expected 87654321", rd); end
        run_access(1'b0, 2'b00, 1'b1, 32'h43, 32'h0, dc, da, st, wm, dn, ms, rd);
        checks++; if (rd !== 32'hFFFFFF87) begin errors++; $display("FAIL lb_rdata: got %h expected ffffff87", rd); end
        run_access(1'b0, 2'b00, 1'b0, 32'h43, 32'h0, dc, da, st, wm, dn, ms, rd);
        checks++; if (rd !== 32'h00000087) begin errors++; $display("FAIL lbu_rdata: got %h expected 00000087", rd); end
        run_access(1'b0, 2'b00, 1'b1, 32'h40, 32'h0, dc, da, st, wm, dn, ms, rd);
        checks++; if (rd !== 32'h00000021) begin errors++; $display("FAIL lb0_rdata: got %h expected 00000021", rd); end
        run_access(1'b0, 2'b01, 1'b1, 32'h42, 32'h0, dc, da, st, wm, dn, ms, rd);
        checks++; if (rd !== 32'hFFFF8765) begin errors++; $display("FAIL lh_rdata: got %h expected ffff8765", rd); end
        run_access(1'b0, 2'b01, 1'b0, 32'hFFFFF040, 32'h0, dc, da, st, wm, dn, ms, rd);
        checks++; if (rd !== 32'h00004321) begin errors++; $display("FAIL lhu_alias_rdata: got %h expected 00004321", rd); end
    endtask

    task automatic test_store_byte();
        int dc, da; logic [7:0] st, wm; logic [31:0] dn, rd; logic ms;
        run_access(1'b1, 2'b00, 1'b0, 32'h41, 32'h000000AA, dc, da, st, wm, dn, ms, rd);
        checks++; if (dc !== 3) begin errors++; $display("FAIL sb_done_cycle: got %0d expected 3", dc); end
        checks++; if (st[3:0] !== 4'b0111) begin errors++; $display("FAIL sb_stall: got %b expected 0111", st[3:0]); end
        checks++; if (wm !== 8'h04) begin errors++; $display("FAIL sb_dm_we: got %b expected 00000100", wm); end
        checks++; if (dn !== 32'h8765AA21) begin errors++; $display("FAIL sb_dm_din: got %h expected 8765aa21", dn); end
        run_access(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, dc, da, st, wm, dn, ms, rd);
        checks++; if (rd !== 32'h8765AA21) begin errors++; $display("FAIL sb_readback: got %h expected 8765aa21", rd); end
        run_access(1'b1, 2'b01, 1'b0, 32'h40, 32'h0000CAFE, dc, da, st, wm, dn, ms, rd);
        checks++; if (dn !== 32'h8765CAFE) begin errors++; $display("FAIL sh_lo_dm_din: got %h expected 8765cafe", dn); end
        poke(10'h010, 32'h87654321);
    endtask

    task automatic test_store_word();
        int dc, da; logic [7:0] st, wm; logic [31:0] dn, rd; logic ms;
        run_access(1'b1, 2'b10, 1'b0, 32'h44, 32'hDEADBEEF, dc, da, st, wm, dn, ms, rd);
        checks++; if (dc !== 2) begin errors++; $display("FAIL sw_done_cycle: got %0d expected 2", dc); end
        checks++; if (wm !== 8'h02) begin errors++; $display("FAIL sw_dm_we: got %b expected 00000010", wm); end
        checks++; if (dn !== 32'hDEADBEEF) begin errors++; $display("FAIL sw_dm_din: got %h expected deadbeef", dn); end
        checks++; if (mem[17] !== 32'hDEADBEEF) begin errors++; $display("FAIL sw_mem: got %h expected deadbeef", mem[17]); end
    endtask

    task automatic test_misalign();
        int dc, da; logic [7:0] st, wm; logic [31:0] dn, rd; logic ms;
        run_access(1'b1, 2'b01, 1'b0, 32'h43, 32'h0000BEEF, dc, da, st, wm, dn, ms, rd);
`ifdef MEM_ALIGN_CHECK_EN
        checks++; if (dc !== 1) begin errors++; $display("FAIL mis_done_cycle: got %0d expected 1", dc); end
        checks++; if (ms !== 1'b1) begin errors++; $display("FAIL mis_flag: got %b expected 1", ms); end
        checks++; if (wm !== 8'h0) begin errors++; $display("FAIL mis_dm_we: got %b expected 0", wm); end
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL mis_rdata: got %h expected 0", rd); end
        checks++; if (mem[16] !== 32'h87654321) begin errors++; $display("FAIL mis_mem: got %h expected 87654321", mem[16]); end
        run_access(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, dc, da, st, wm, dn, ms, rd);
        checks++; if (ms !== 1'b0) begin errors++; $display("FAIL aligned_no_mis: got %b expected 0", ms); end
`else
        checks++; if (dc !== 3) begin errors++; $display("FAIL nochk_done_cycle: got %0d expected 3", dc); end
        checks++; if (ms !== 1'b0) begin errors++; $display("FAIL nochk_misalign: got %b expected 0", ms); end
        checks++; if (mem[16] !== 32'hBEEF4321) begin errors++; $display("FAIL nochk_mem: got %h expected beef4321", mem[16]); end
        run_access(1'b0, 2'b10, 1'b0, 32'h42, 32'h0, dc, da, st, wm, dn, ms, rd);
        checks++; if (rd !== 32'hBEEF4321) begin errors++; $display("FAIL nochk_lw_mask: got %h expected beef4321", rd); end
        run_access(1'b0, 2'b11, 1'b0, 32'h41, 32'h0, dc, da, st, wm, dn, ms, rd);
        checks++; if (rd !== 32'hBEEF4321) begin errors++; $display("FAIL nochk_size3_word: got %h expected beef4321", rd); end
        checks++; if (dc !== 2) begin errors++; $display("FAIL nochk_size3_cycle: got %0d expected 2", dc); end
        poke(10'h010, 32'h87654321);
`endif
    endtask

    task automatic test_reset_mid_write();
        req = 1'b1; we = 1'b1; size = 2'b01; sign_ext = 1'b0; addr = 32'h40; wdata = 32'h00001234;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1; req = 1'b0;
        #1;
        checks++; if (dm_we !== 1'b0) begin errors++; $display("FAIL rstwr_dm_we: got %b expected 0", dm_we); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rstwr_stall: got %b expected 0", stall); end
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        $display("access reset during halfword store write cycle");
        checks++; if (mem[16] !== 32'h87654321) begin errors++; $display("FAIL rstwr_mem: got %h expected 87654321", mem[16]); end
        checks++; if ({stall, done, misalign, dm_we} !== 4'b0) begin errors++; $display("FAIL rstwr_ctrl: got %b expected 0000", {stall, done, misalign, dm_we}); end
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL rstwr_rdata: got %h expected 0", rdata); end
        checks++; if (dm_din !== 32'h0) begin errors++; $display("FAIL rstwr_dm_din: got %h expected 0", dm_din); end
        checks++; if (dm_addr !== 10'h0) begin errors++; $display("FAIL rstwr_dm_addr: got %h expected 0", dm_addr); end
        @(posedge clk); #1;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rstwr_no_done: got %b expected 0", done); end
    endtask

    task automatic test_back_to_back();
        int dc1, da1, dc2, da2, n0; logic [7:0] st, wm; logic [31:0] dn, rd1, rd2; logic ms;
        n0 = done_count;
        run_access(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, dc1, da1, st, wm, dn, ms, rd1);
        run_access(1'b0, 2'b10, 1'b0, 32'h44, 32'h0, dc2, da2, st, wm, dn, ms, rd2);
        checks++; if (da2 - da1 !== 3) begin errors++; $display("FAIL b2b_spacing: got %0d expected 3", da2 - da1); end
        checks++; if (done_count - n0 !== 2) begin errors++; $display("FAIL b2b_done_pulses: got %0d expected 2", done_count - n0); end
        checks++; if (rd1 !== 32'h87654321) begin errors++; $display("FAIL b2b_rdata1: got %h expected 87654321", rd1); end
        checks++; if (rd2 !== 32'hDEADBEEF) begin errors++; $display("FAIL b2b_rdata2: got %h expected deadbeef", rd2); end
    endtask

    initial begin
        test_reset();
        test_load();
        test_store_byte();
        test_store_word();
        test_misalign();
        test_reset_mid_write();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
